pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Parametrised successor of the fetch program counter: holds the current fetch address and advances by a fixed increment when enabled.
- Adds redirect (branch/jump) and trap loads with fixed priority, misaligned-target detection with a sticky fault, a previous-PC output, and an advance counter.
- Sits at the front of the fetch stage, feeding instruction memory and the decode pipeline.

Parameters:
- XLEN, 32, width of PC and all address ports.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- INC, 4, advance step in bytes.
- ALIGN_BITS, 2, low target bits that must be zero for a legal redirect.
- CNT_W, 32, width of the advance counter.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- res  in  1  reset, synchronous, active-high.
- En  in  1  advance enable; 0 = stall.
- redirect  in  1  load redirect_target this cycle.
- redirect_target  in  XLEN  branch/jump target.
- trap  in  1  load trap_vector this cycle.
- trap_vector  in  XLEN  trap handler address.
- misalign_clr  in  1  clear the sticky misalign fault.
- pc  out  XLEN  current fetch address (registered).
- pc_old  out  XLEN  PC value held before the most recent PC change (registered).
- pc_plus  out  XLEN  pc + INC, combinational, modulo 2^XLEN.
- redirected  out  1  one-cycle pulse in the cycle after a redirect or trap load.
- misalign  out  1  sticky fault flag.
- misalign_addr  out  XLEN  captured illegal target.
- adv_count  out  CNT_W  number of sequential advances since reset.

Behaviour:
- Reset values on a clock edge with res=1, which overrides all other inputs:
  - pc=RESET_VECTOR, pc_old=RESET_VECTOR.
  - redirected=0, misalign=0, misalign_addr=0, adv_count=0.
- Load priority when res=0, evaluated per clock edge, highest first: trap, then legal redirect, then advance, then hold.
- Trap load:
  - pc <= trap_vector with its low ALIGN_BITS forced to 0.
  - pc_old <= pc.
  - redirected <= 1.
  - Clears misalign in the same edge.
  - Ignores En and misalign.
- Redirect with trap=0:
  - Legal if redirect_target[ALIGN_BITS-1:0]==0: pc <= redirect_target, pc_old <= pc, redirected <= 1. Ignores En.
  - Illegal otherwise: pc and pc_old hold, misalign <= 1, misalign_addr <= redirect_target, redirected <= 0.
- Advance when trap=0, redirect=0, En=1 and misalign=0:
  - pc <= pc + INC, wrapping modulo 2^XLEN; for example, all-ones-minus-3 wraps to 0 with INC=4.
  - pc_old <= pc.
  - adv_count <= adv_count + 1, wrapping at 2^CNT_W.
- Hold: no enabled event, or misalign=1 with no trap. pc, pc_old and adv_count are unchanged.
- Redirect and trap loads do not increment adv_count.
- redirected is 0 in every cycle not immediately following a load.
- misalign is sticky until one of:
  - res.
  - trap.
  - misalign_clr=1 with no new illegal redirect in the same cycle. A same-cycle new illegal redirect wins: flag stays 1 and the address is recaptured.
- While misalign=1, a legal redirect still loads pc but does not clear the flag.
- Zero-latency combinational paths: pc_plus only. All other outputs are flops.
- Reset mid-stall or mid-fault: the next edge with res=1 restores the reset state regardless of other inputs.

Test Plan:
- res=1 for 2 cycles, then En=1 for 3 cycles (INC=4) -> pc 0,4,8,C; pc_old 0,0,4,8; adv_count 3.
- At pc=0x10, En=0 with redirect=1, target=0x200 -> next cycle pc=0x200, pc_old=0x10, redirected=1 for exactly one cycle, adv_count unchanged.
- redirect=1 and trap=1 same cycle, target=0x300, trap_vector=0x1003 -> pc=0x1000, redirected=1, misalign=0.
- redirect=1, target=0x202 -> pc holds, misalign=1, misalign_addr=0x202.
  - En=1 for 2 cycles -> pc still holds.
  - Then trap, vector 0x80 -> pc=0x80, misalign=0.
- redirect to 0xFFFF_FFFC, then En=1 -> pc=0x0, pc_old=0xFFFF_FFFC, pc_plus=0x4.
- After 5 advances, assert res=1 with En=1 and redirect=1 in the same cycle -> pc=RESET_VECTOR, adv_count=0, redirected=0.

Source files
------------

// File: rtl/pc_unit.sv
// Fetch program counter: sequential advance plus trap/redirect loads with
// misaligned-target detection, previous-PC tracking and an advance counter.
module pc_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     INC          = 4,
  parameter int unsigned     ALIGN_BITS   = 2,
  parameter int unsigned     CNT_W        = 32
) (
  input  logic             clk,
  input  logic             res,
  input  logic             En,
  input  logic             redirect,
  input  logic [XLEN-1:0]  redirect_target,
  input  logic             trap,
  input  logic [XLEN-1:0]  trap_vector,
  input  logic             misalign_clr,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  pc_old,
  output logic [XLEN-1:0]  pc_plus,
  output logic             redirected,
  output logic             misalign,
  output logic [XLEN-1:0]  misalign_addr,
  output logic [CNT_W-1:0] adv_count
);

  // Ones above the alignment field, zeros within it.
  localparam logic [XLEN-1:0] ALIGN_MASK = {XLEN{1'b1}} << ALIGN_BITS;

  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_pc_old;
  logic             r_redirected;
  logic             r_misalign;
  logic [XLEN-1:0]  r_misalign_addr;
  logic [CNT_W-1:0] r_adv_count;

  logic             w_target_ok;
  logic [XLEN-1:0]  w_pc_plus;
  logic [XLEN-1:0]  w_pc_nxt;
  logic [XLEN-1:0]  w_pc_old_nxt;
  logic             w_redirected_nxt;
  logic             w_misalign_nxt;
  logic [XLEN-1:0]  w_misalign_addr_nxt;
  logic [CNT_W-1:0] w_adv_count_nxt;

  assign w_target_ok = (redirect_target & ~ALIGN_MASK) == '0;
  assign w_pc_plus   = r_pc + XLEN'(INC);

  always_comb begin
    w_pc_nxt            = r_pc;
    w_pc_old_nxt        = r_pc_old;
    w_redirected_nxt    = 1'b0;
    w_misalign_nxt      = r_misalign;
    w_misalign_addr_nxt = r_misalign_addr;
    w_adv_count_nxt     = r_adv_count;

    if (trap) begin
      w_pc_nxt         = trap_vector & ALIGN_MASK;
      w_pc_old_nxt     = r_pc;
      w_redirected_nxt = 1'b1;
      w_misalign_nxt   = 1'b0;
    end else if (redirect && w_target_ok) begin
      // A legal redirect loads even while faulted but never clears the flag itself.
      w_pc_nxt         = redirect_target;
      w_pc_old_nxt     = r_pc;
      w_redirected_nxt = 1'b1;
      if (misalign_clr) w_misalign_nxt = 1'b0;
    end else if (redirect) begin
      w_misalign_nxt      = 1'b1;
      w_misalign_addr_nxt = redirect_target;
    end else begin
      // Advance is gated by the flag as it stood before this edge's clear.
      if (En && !r_misalign) begin
        w_pc_nxt        = w_pc_plus;
        w_pc_old_nxt    = r_pc;
        w_adv_count_nxt = r_adv_count + CNT_W'(1);
      end
      if (misalign_clr) w_misalign_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      r_pc            <= RESET_VECTOR;
      r_pc_old        <= RESET_VECTOR;
      r_redirected    <= 1'b0;
      r_misalign      <= 1'b0;
      r_misalign_addr <= '0;
      r_adv_count     <= '0;
    end else begin
      r_pc            <= w_pc_nxt;
      r_pc_old        <= w_pc_old_nxt;
      r_redirected    <= w_redirected_nxt;
      r_misalign      <= w_misalign_nxt;
      r_misalign_addr <= w_misalign_addr_nxt;
      r_adv_count     <= w_adv_count_nxt;
    end
  end

  assign pc            = r_pc;
  assign pc_old        = r_pc_old;
  assign pc_plus       = w_pc_plus;
  assign redirected    = r_redirected;
  assign misalign      = r_misalign;
  assign misalign_addr = r_misalign_addr;
  assign adv_count     = r_adv_count;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: a behavioural model pushes expected state per
// step into a scoreboard queue; each entry is popped and checked after the edge.
module tb_pc_unit;

  logic        clk;
  logic        res;
  logic        En;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        trap;
  logic [31:0] trap_vector;
  logic        misalign_clr;
  logic [31:0] pc;
  logic [31:0] pc_old;
  logic [31:0] pc_plus;
  logic        redirected;
  logic        misalign;
  logic [31:0] misalign_addr;
  logic [31:0] adv_count;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] old;
    logic [31:0] plus;
    logic        red;
    logic        mis;
    logic [31:0] maddr;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];

  logic [31:0] m_pc, m_old, m_maddr, m_cnt;
  logic        m_red, m_mis;

  int errors = 0;
  int checks = 0;

  pc_unit #(
    .XLEN(32),
    .RESET_VECTOR(32'h0000_0000),
    .INC(4),
    .ALIGN_BITS(2),
    .CNT_W(32)
  ) dut (
    .clk(clk),
    .res(res),
    .En(En),
    .redirect(redirect),
    .redirect_target(redirect_target),
    .trap(trap),
    .trap_vector(trap_vector),
    .misalign_clr(misalign_clr),
    .pc(pc),
    .pc_old(pc_old),
    .pc_plus(pc_plus),
    .redirected(redirected),
    .misalign(misalign),
    .misalign_addr(misalign_addr),
    .adv_count(adv_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference behaviour, written from the load-priority description.
  task automatic model(input logic r, e, rd, input logic [31:0] tgt,
                       input logic tr, input logic [31:0] tv, input logic clr);
    logic prev_mis;
    prev_mis = m_mis;
    if (r) begin
      m_pc = 32'h0; m_old = 32'h0; m_red = 1'b0;
      m_mis = 1'b0; m_maddr = 32'h0; m_cnt = 32'h0;
    end else if (tr) begin
      m_old = m_pc; m_pc = {tv[31:2], 2'b00}; m_red = 1'b1; m_mis = 1'b0;
    end else if (rd && tgt[1:0] == 2'b00) begin
      m_old = m_pc; m_pc = tgt; m_red = 1'b1;
      if (clr) m_mis = 1'b0;
    end else if (rd) begin
      m_red = 1'b0; m_mis = 1'b1; m_maddr = tgt;
    end else begin
      m_red = 1'b0;
      if (e && !prev_mis) begin
        m_old = m_pc; m_pc = m_pc + 32'd4; m_cnt = m_cnt + 32'd1;
      end
      if (clr) m_mis = 1'b0;
    end
  endtask

  task automatic step(input logic r, e, rd, input logic [31:0] tgt,
                      input logic tr, input logic [31:0] tv, input logic clr);
    exp_t x;
    res = r; En = e; redirect = rd; redirect_target = tgt;
    trap = tr; trap_vector = tv; misalign_clr = clr;
    model(r, e, rd, tgt, tr, tv, clr);
    x.pc = m_pc; x.old = m_old; x.plus = m_pc + 32'd4; x.red = m_red;
    x.mis = m_mis; x.maddr = m_maddr; x.cnt = m_cnt;
    q.push_back(x);
    @(posedge clk);
    #1;
    x = q.pop_front();
    chk("pc", pc, x.pc);
    chk("pc_old", pc_old, x.old);
    chk("pc_plus", pc_plus, x.plus);
    chk("redirected", {31'd0, redirected}, {31'd0, x.red});
    chk("misalign", {31'd0, misalign}, {31'd0, x.mis});
    chk("misalign_addr", misalign_addr, x.maddr);
    chk("adv_count", adv_count, x.cnt);
  endtask

  initial begin
    res = 1'b1; En = 1'b0; redirect = 1'b0; redirect_target = '0;
    trap = 1'b0; trap_vector = '0; misalign_clr = 1'b0;
    m_pc = '0; m_old = '0; m_red = 1'b0; m_mis = 1'b0; m_maddr = '0; m_cnt = '0;
    @(negedge clk);

    // Reset, then three advances
    step(1, 0, 0, 32'h0, 0, 32'h0, 0);
    step(1, 1, 1, 32'h44, 1, 32'h80, 1);
    chk("reset_pc", pc, 32'h0);
    step(0, 1, 0, 32'h0, 0, 32'h0, 0);
    step(0, 1, 0, 32'h0, 0, 32'h0, 0);
    step(0, 1, 0, 32'h0, 0, 32'h0, 0);
    chk("adv3_pc", pc, 32'hC);
    chk("adv3_old", pc_old, 32'h8);
    chk("adv3_cnt", adv_count, 32'd3);

    // Stall, then one advance to 0x10, then redirect with En=0
    step(0, 0, 0, 32'h0, 0, 32'h0, 0);
    step(0, 1, 0, 32'h0, 0, 32'h0, 0);
    step(0, 0, 1, 32'h200, 0, 32'h0, 0);
    chk("redir_pc", pc, 32'h200);
    chk("redir_old", pc_old, 32'h10);
    chk("redir_pulse", {31'd0, redirected}, 32'd1);
    step(0, 0, 0, 32'h0, 0, 32'h0, 0);
    chk("redir_pulse_end", {31'd0, redirected}, 32'd0);

    // Trap beats redirect; low vector bits forced to zero
    step(0, 1, 1, 32'h300, 1, 32'h1003, 0);
    chk("trap_pc", pc, 32'h1000);

    // Illegal redirect: hold and stick, En ignored, trap clears
    step(0, 0, 1, 32'h202, 0, 32'h0, 0);
    chk("mis_addr", misalign_addr, 32'h202);
    step(0, 1, 0, 32'h0, 0, 32'h0, 0);
    step(0, 1, 0, 32'h0, 0, 32'h0, 0);
    chk("mis_hold_pc", pc, 32'h1000);
    step(0, 1, 0, 32'h0, 1, 32'h80, 0);
    chk("mis_trap_clr", {31'd0, misalign}, 32'd0);

    // misalign_clr alone clears; same-cycle illegal redirect wins
    step(0, 0, 1, 32'h205, 0, 32'h0, 0);
    step(0, 1, 0, 32'h0, 0, 32'h0, 1);
    step(0, 0, 1, 32'h206, 0, 32'h0, 0);
    step(0, 0, 1, 32'h207, 0, 32'h0, 1);
    chk("mis_recapture", misalign_addr, 32'h207);
    // Legal redirect while faulted loads pc, flag stays
    step(0, 0, 1, 32'h400, 0, 32'h0, 0);
    chk("mis_legal_pc", pc, 32'h400);
    step(0, 0, 1, 32'h500, 0, 32'h0, 1);
    step(0, 1, 0, 32'h0, 0, 32'h0, 0);

    // Wrap from the top of the address space
    step(0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0, 0);
    step(0, 1, 0, 32'h0, 0, 32'h0, 0);
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_old", pc_old, 32'hFFFF_FFFC);
    chk("wrap_plus", pc_plus, 32'h4);

    // A few random steps, then five advances and reset with competing inputs
    for (int unsigned i = 0; i < 12; i++)
      step(0, 1'($urandom), 1'($urandom_range(0, 3) == 0), $urandom & 32'hFFFF_FFF3,
           1'($urandom_range(0, 7) == 0), $urandom, 1'($urandom_range(0, 3) == 0));
    step(0, 0, 0, 32'h0, 1, 32'h100, 0);
    for (int unsigned i = 0; i < 5; i++)
      step(0, 1, 0, 32'h0, 0, 32'h0, 0);
    step(1, 1, 1, 32'h600, 0, 32'h0, 0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_cnt", adv_count, 32'd0);
    chk("rst_red", {31'd0, redirected}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
